// File: rtl/ram_alu_sequencer.sv
// ram_alu_sequencer: walks instruction RAM from address 0, decoding each word into an ALU op and one result write.
module ram_alu_sequencer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int ALU_OP_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    ram_zero,
   input  logic [2:0]              funct,
   input  logic                    add_rshift_type,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic                    ram_rd_en,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic                    addr_sel,
   output logic                    wr_en,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    aborted,
   output logic [ADDR_WIDTH:0]     op_count
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, EXEC, DONE} state_t;
   localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);
   state_t state_q, state_d;
   logic start_q, launch;
   logic [2:0] lat_q, lat_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH:0] op_count_q, op_count_d;
   logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
   logic [3:0] dec_op;
   logic err_q, err_d, aborted_q, aborted_d;
   logic rd_en_q, rd_en_d, exec_q, exec_d, busy_q, busy_d, done_q, done_d;
   assign launch = start & ~start_q;
   // ADD/SUB and SRL/SRA share a funct; the type bit picks the second of each pair
   assign dec_op = (funct == 3'd0) ? {3'b0, add_rshift_type} :
                   (funct < 3'd5)  ? {1'b0, funct} + 4'd1 :
                   (funct == 3'd5) ? 4'd6 + {3'b0, add_rshift_type} :
                                     {1'b0, funct} + 4'd2;
   always_comb begin
      state_d = state_q;
      lat_d = lat_q;
      pc_d = pc_q;
      op_count_d = op_count_q;
      alu_op_d = alu_op_q;
      err_d = err_q;
      aborted_d = aborted_q;
      case (state_q)
         IDLE, DONE: begin
            if (launch) begin
               state_d = FETCH;
               pc_d = '0;
               op_count_d = '0;
               err_d = 1'b0;
               aborted_d = 1'b0;
            end
         end
         FETCH: begin
            state_d = (READ_LATENCY == 1) ? DECODE : WAIT;
            lat_d = LAT_INIT;
         end
         WAIT: begin
            lat_d = lat_q - 3'd1;
            state_d = (lat_q == 3'd1) ? DECODE : WAIT;
         end
         DECODE: begin
            state_d = ram_zero ? DONE : EXEC;
            alu_op_d = ram_zero ? alu_op_q : ALU_OP_WIDTH'(dec_op);
         end
         EXEC: begin
            op_count_d = op_count_q + 1'b1;
            err_d = (pc_q == '1);
            state_d = (pc_q == '1) ? DONE : FETCH;
            pc_d = (pc_q == '1) ? pc_q : pc_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // abort outranks every in-run event and discards that cycle's updates
      if (abort && busy_q) begin
         state_d = DONE;
         aborted_d = 1'b1;
         pc_d = pc_q;
         op_count_d = op_count_q;
         alu_op_d = alu_op_q;
         err_d = err_q;
      end
      rd_en_d = state_d == FETCH;
      exec_d = state_d == EXEC;
      busy_d = state_d inside {FETCH, WAIT, DECODE, EXEC};
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         lat_q <= '0;
         pc_q <= '0;
         op_count_q <= '0;
         alu_op_q <= '0;
         err_q <= 1'b0;
         aborted_q <= 1'b0;
         rd_en_q <= 1'b0;
         exec_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         lat_q <= lat_d;
         pc_q <= pc_d;
         op_count_q <= op_count_d;
         alu_op_q <= alu_op_d;
         err_q <= err_d;
         aborted_q <= aborted_d;
         rd_en_q <= rd_en_d;
         exec_q <= exec_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign ram_addr = pc_q;
   assign ram_rd_en = rd_en_q;
   assign alu_op = alu_op_q;
   assign addr_sel = exec_q;
   // a same-cycle abort or reset must keep the write from reaching the datapath
   assign wr_en = exec_q & ~abort & rst;
   assign busy = busy_q;
   assign done = done_q;
   assign err = err_q;
   assign aborted = aborted_q;
   assign op_count = op_count_q;
endmodule

// File: tb/tb_ram_alu_sequencer.sv
// tb_ram_alu_sequencer: drives two sequencer configurations against RAM models and a cycle-level reference.
module tb_ram_alu_sequencer;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, sel = 1'b0;
   int compared = 0, mismatched = 0;
   logic [4:0] mem [256];
   always #5 clk = ~clk;

   logic a_zero, a_type, a_rd, a_sel, a_wr, a_busy, a_done, a_err, a_ab;
   logic [2:0] a_funct;
   logic [7:0] a_addr;
   logic [3:0] a_op;
   logic [8:0] a_cnt;
   logic b_zero, b_type, b_rd, b_sel, b_wr, b_busy, b_done, b_err, b_ab;
   logic [2:0] b_funct;
   logic [2:0] b_addr;
   logic [3:0] b_op;
   logic [3:0] b_cnt;

   ram_alu_sequencer #(.ADDR_WIDTH(8), .READ_LATENCY(1), .ALU_OP_WIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
      .ram_zero(a_zero), .funct(a_funct), .add_rshift_type(a_type),
      .ram_addr(a_addr), .ram_rd_en(a_rd), .alu_op(a_op), .addr_sel(a_sel), .wr_en(a_wr),
      .busy(a_busy), .done(a_done), .err(a_err), .aborted(a_ab), .op_count(a_cnt));

   ram_alu_sequencer #(.ADDR_WIDTH(3), .READ_LATENCY(3), .ALU_OP_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
      .ram_zero(b_zero), .funct(b_funct), .add_rshift_type(b_type),
      .ram_addr(b_addr), .ram_rd_en(b_rd), .alu_op(b_op), .addr_sel(b_sel), .wr_en(b_wr),
      .busy(b_busy), .done(b_done), .err(b_err), .aborted(b_ab), .op_count(b_cnt));

   // RAM models: word = {zero, funct, type}; invalid slots present a non-terminating AND word
   logic [4:0] pa = '0;
   logic va = 1'b0;
   logic [4:0] pb [3];
   logic [2:0] vb = '0;
   always @(posedge clk) begin
      pa <= mem[a_addr];
      va <= a_rd;
      pb[0] <= mem[{5'b0, b_addr}];
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      vb <= {vb[1:0], b_rd};
   end
   assign a_zero = va & pa[4];
   assign a_funct = va ? pa[3:1] : 3'b111;
   assign a_type = va & pa[0];
   assign b_zero = vb[2] & pb[2][4];
   assign b_funct = vb[2] ? pb[2][3:1] : 3'b111;
   assign b_type = vb[2] & pb[2][0];

   logic [7:0] o_addr;
   logic [3:0] o_op;
   logic [8:0] o_cnt;
   logic o_rd, o_sel, o_wr, o_busy, o_done, o_err, o_ab;
   logic [27:0] o_all;
   assign o_addr = sel ? {5'b0, b_addr} : a_addr;
   assign o_op = sel ? b_op : a_op;
   assign o_cnt = sel ? {5'b0, b_cnt} : a_cnt;
   assign o_rd = sel ? b_rd : a_rd;
   assign o_sel = sel ? b_sel : a_sel;
   assign o_wr = sel ? b_wr : a_wr;
   assign o_busy = sel ? b_busy : a_busy;
   assign o_done = sel ? b_done : a_done;
   assign o_err = sel ? b_err : a_err;
   assign o_ab = sel ? b_ab : a_ab;
   assign o_all = {o_addr, o_rd, o_op, o_sel, o_wr, o_busy, o_done, o_err, o_ab, o_cnt};

   function automatic logic [3:0] ref_op(input logic [2:0] f, input logic t);
      case (f)
         3'd0: return t ? 4'd1 : 4'd0;
         3'd1: return 4'd2;
         3'd2: return 4'd3;
         3'd3: return 4'd4;
         3'd4: return 4'd5;
         3'd5: return t ? 4'd7 : 4'd6;
         3'd6: return 4'd8;
         default: return 4'd9;
      endcase
   endfunction

   task automatic select(input logic s);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      sel = s;
   endtask

   task automatic fill(input int n);
      for (int a = 0; a < n; a++) mem[a] = {1'b0, 4'($urandom)};
      mem[n] = 5'b10000;
   endtask

   // One run on the selected DUT; abort_cyc < 0 means no abort. Cycle 0 is the FETCH after the launch edge.
   task automatic run(input string name, input int abort_cyc);
      int p, rl, aw_max, nfetch, done_exp, cyc, bad, rd_cnt, rd_exp, n;
      bit term, ab_exp, err_exp;
      logic [3:0] exp_ops[$], got_ops[$];
      int got_cyc[$];
      rl = sel ? 3 : 1;
      p = rl + 2;
      aw_max = sel ? 7 : 255;
      term = 1'b0;
      for (int a = 0; a <= aw_max; a++) begin
         if (mem[a][4] === 1'b1) begin
            term = 1'b1;
            break;
         end
         exp_ops.push_back(ref_op(mem[a][3:1], mem[a][0]));
      end
      nfetch = exp_ops.size() + int'(term);
      done_exp = term ? exp_ops.size() * p + rl + 1 : exp_ops.size() * p;
      ab_exp = abort_cyc >= 0 && abort_cyc < done_exp;
      if (ab_exp) done_exp = abort_cyc + 1;
      err_exp = !term && !ab_exp;
      while (exp_ops.size() > 0 && (exp_ops.size() - 1) * p + rl + 1 >= done_exp - int'(ab_exp)) exp_ops.pop_back();
      rd_exp = 0;
      for (int k = 0; k < nfetch; k++) if (k * p <= done_exp - 1) rd_exp++;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cyc = 0;
      bad = 0;
      rd_cnt = 0;
      forever begin
         @(negedge clk);
         abort = (cyc == abort_cyc);
         #1;
         if (cyc == 0) begin
            compared++;
            if ({o_busy, o_done, o_err, o_ab, o_cnt, o_addr, o_rd} !== {4'b1000, 9'd0, 8'd0, 1'b1}) begin
               mismatched++;
               $display("FAIL %s launch_state got busy/done/err/ab=%b%b%b%b cnt=%0d addr=%0d rd=%b required 1000 0 0 1", name, o_busy, o_done, o_err, o_ab, o_cnt, o_addr, o_rd);
            end
         end
         if (o_done) break;
         if (!o_busy || (o_rd && o_sel) || (o_wr && !o_sel)) bad++;
         if (o_rd) rd_cnt++;
         if (o_wr) begin
            got_ops.push_back(o_op);
            got_cyc.push_back(cyc);
         end
         cyc++;
         if (cyc > 2000) begin
            compared++;
            mismatched++;
            $display("FAIL %s timeout got no done after %0d cycles required done at %0d", name, cyc, done_exp);
            break;
         end
      end
      abort = 1'b0;
      compared++;
      if (cyc != done_exp) begin
         mismatched++;
         $display("FAIL %s done_cycle got %0d required %0d", name, cyc, done_exp);
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL %s busy_addr_sel got %0d bad cycles required 0", name, bad);
      end
      compared++;
      if (rd_cnt != rd_exp) begin
         mismatched++;
         $display("FAIL %s rd_count got %0d required %0d", name, rd_cnt, rd_exp);
      end
      compared++;
      if (got_ops.size() != exp_ops.size()) begin
         mismatched++;
         $display("FAIL %s write_count got %0d required %0d", name, got_ops.size(), exp_ops.size());
      end
      n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
      for (int i = 0; i < n; i++) begin
         compared++;
         if (got_ops[i] !== exp_ops[i] || got_cyc[i] != i * p + rl + 1) begin
            mismatched++;
            $display("FAIL %s write[%0d] got op=%0d cyc=%0d required op=%0d cyc=%0d", name, i, got_ops[i], got_cyc[i], exp_ops[i], i * p + rl + 1);
         end
      end
      compared++;
      if ({o_cnt, o_addr, o_err, o_ab, o_busy, o_rd, o_wr, o_sel} !== {9'(exp_ops.size()), 8'((done_exp - 1) / p), err_exp, ab_exp, 4'b0}) begin
         mismatched++;
         $display("FAIL %s final got cnt=%0d addr=%0d err=%b ab=%b strobes=%b%b%b%b required cnt=%0d addr=%0d err=%b ab=%b strobes=0000", name, o_cnt, o_addr, o_err, o_ab, o_busy, o_rd, o_wr, o_sel, exp_ops.size(), (done_exp - 1) / p, err_exp, ab_exp);
      end
      if (!ab_exp && exp_ops.size() > 0) begin
         compared++;
         if (o_op !== exp_ops[$]) begin
            mismatched++;
            $display("FAIL %s alu_op_hold got %0d required %0d", name, o_op, exp_ops[$]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         compared++;
         if (o_all !== '0) begin
            mismatched++;
            $display("FAIL reset_dut%0d got %h required 0", s, o_all);
         end
      end
      sel = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      mem[0] = {1'b0, 3'b000, 1'b1};
      mem[1] = {1'b0, 3'b101, 1'b1};
      mem[2] = 5'b10000;
      select(1'b0);
      run("basic_rl1", -1);
      select(1'b1);
      run("basic_rl3", -1);
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) mem[i] = {1'b0, 3'(i >> 1), 1'(i)};
      mem[16] = 5'b10000;
      select(1'b0);
      run("sweep", -1);
   endtask

   task automatic test_exhaust();
      fill(8);
      select(1'b1);
      run("exhaust", -1);
   endtask

   task automatic test_abort();
      fill(3);
      select(1'b0);
      run("abort_exec2", 5);
   endtask

   task automatic test_hold_start();
      int bad = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (!o_done || o_busy || o_cnt !== 9'd1 || !o_ab) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL hold_start got %0d relaunch cycles required 0", bad);
      end
      run("relaunch", -1);
   endtask

   task automatic test_random();
      select(1'b0);
      repeat (4) begin
         fill($urandom_range(0, 20));
         run("rand_a", -1);
      end
      select(1'b1);
      repeat (2) begin
         fill($urandom_range(0, 8));
         run("rand_b", -1);
      end
      repeat (3) begin
         fill(8);
         run("abort_rand_b", $urandom_range(0, 39));
      end
   endtask

   task automatic test_reset_mid();
      fill(8);
      select(1'b1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      compared++;
      if (o_all !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_wait got %h required 0", o_all);
      end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      #1;
      compared++;
      if (o_wr !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_mid_exec_pre got wr_en=%b required 1", o_wr);
      end
      rst = 1'b0;
      #1;
      compared++;
      if (o_wr !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_exec_wr got wr_en=%b required 0", o_wr);
      end
      @(negedge clk);
      #1;
      compared++;
      if (o_all !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_exec got %h required 0", o_all);
      end
      start = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 5'b10000;
      test_reset();
      test_basic();
      test_sweep();
      test_exhaust();
      test_abort();
      test_hold_start();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
